// File: rtl/integrate_dump.sv
`default_nettype none
// ============================================================================
// Module   : integrate_dump
// Purpose  : Six-lane integrate-and-dump for early/prompt/late I/Q correlator
//            products. Samples are summed until a C/A epoch or until
//            MAX_SAMPLES samples have been taken. The sums are then handed to
//            the loop filters through a one-deep valid/ready output register.
// Ports    : CLK, RST (async active-low)
//            sample_valid, epoch, in_{e,p,l}_{i,q}     - sample input side
//            out_{e,p,l}_{i,q}, out_count, out_valid   - held dump
//            out_ready                                 - consumer accept
//            overrun, timeout                          - one-cycle pulses
//            sat_flag                                  - clip seen in held dump
// Config   : INTEGRATE_DUMP_SATURATE_EN - clamp accumulators on overflow and
//            report clipping on sat_flag. When the macro is undefined the
//            accumulators wrap and sat_flag is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module integrate_dump #(
  parameter int IN_W        = 16,
  parameter int ACC_W       = 32,
  parameter int MAX_SAMPLES = 16368,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             sample_valid,
  input  logic             epoch,
  input  logic [IN_W-1:0]  in_e_i,
  input  logic [IN_W-1:0]  in_e_q,
  input  logic [IN_W-1:0]  in_p_i,
  input  logic [IN_W-1:0]  in_p_q,
  input  logic [IN_W-1:0]  in_l_i,
  input  logic [IN_W-1:0]  in_l_q,
  output logic [ACC_W-1:0] out_e_i,
  output logic [ACC_W-1:0] out_e_q,
  output logic [ACC_W-1:0] out_p_i,
  output logic [ACC_W-1:0] out_p_q,
  output logic [ACC_W-1:0] out_l_i,
  output logic [ACC_W-1:0] out_l_q,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             timeout,
  output logic             sat_flag
);

  localparam int c_lanes = 6;

  // Lane order: e_i, e_q, p_i, p_q, l_i, l_q
  logic        [IN_W-1:0]  w_in   [c_lanes];
  logic signed [ACC_W-1:0] w_sum  [c_lanes];
  logic signed [ACC_W-1:0] r_acc  [c_lanes];
  logic        [ACC_W-1:0] r_out  [c_lanes];
  logic        [CNT_W-1:0] r_cnt;
  logic        [CNT_W-1:0] w_cnt_inc;
  logic        [CNT_W-1:0] r_out_count;
  logic                    r_out_valid;
  logic                    r_overrun;
  logic                    r_timeout;
  logic                    w_limit;
  logic                    w_dump;

  assign w_in[0] = in_e_i;
  assign w_in[1] = in_e_q;
  assign w_in[2] = in_p_i;
  assign w_in[3] = in_p_q;
  assign w_in[4] = in_l_i;
  assign w_in[5] = in_l_q;

  // The limit sample itself is part of the period, so the dump fires when the
  // counter already holds MAX_SAMPLES-1 and one more sample arrives.
  assign w_limit   = sample_valid && (r_cnt == CNT_W'(MAX_SAMPLES - 1));
  assign w_dump    = epoch || w_limit;
  assign w_cnt_inc = r_cnt + CNT_W'(sample_valid);

`ifdef INTEGRATE_DUMP_SATURATE_EN
  logic [c_lanes-1:0] w_clip;
  logic               r_sticky;
  logic               r_sat_flag;
`endif

  // Per-lane next-sum. A non-valid cycle adds zero, so w_sum is always the
  // value the accumulator would take (and the value to dump) this cycle.
  for (genvar k = 0; k < c_lanes; k++) begin : g_lane
    logic signed [ACC_W-1:0] w_addend;
    assign w_addend = sample_valid ? ACC_W'($signed(w_in[k])) : '0;
`ifdef INTEGRATE_DUMP_SATURATE_EN
    localparam logic [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};
    logic [ACC_W:0] w_wide;
    assign w_wide    = {r_acc[k][ACC_W-1], r_acc[k]} + {w_addend[ACC_W-1], w_addend};
    // One guard bit: overflow shows as the two top bits disagreeing, and the
    // guard bit then carries the true sign of the result.
    assign w_clip[k] = w_wide[ACC_W] ^ w_wide[ACC_W-1];
    assign w_sum[k]  = !w_clip[k]    ? w_wide[ACC_W-1:0] :
                       w_wide[ACC_W] ? c_acc_min : c_acc_max;
`else
    assign w_sum[k]  = r_acc[k] + w_addend;
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < c_lanes; k++) begin
        r_acc[k] <= '0;
        r_out[k] <= '0;
      end
      r_cnt       <= '0;
      r_out_count <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_timeout   <= 1'b0;
    end else if (w_dump) begin
      for (int k = 0; k < c_lanes; k++) begin
        r_out[k] <= w_sum[k];
        r_acc[k] <= '0;
      end
      r_cnt       <= '0;
      r_out_count <= w_cnt_inc;
      r_out_valid <= 1'b1;
      // A dump landing in the same cycle the consumer takes the old one is a
      // clean hand-over, not an overrun.
      r_overrun   <= r_out_valid && !out_ready;
      r_timeout   <= w_limit && !epoch;
    end else begin
      for (int k = 0; k < c_lanes; k++) begin
        r_acc[k] <= w_sum[k];
      end
      r_cnt     <= w_cnt_inc;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
      if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef INTEGRATE_DUMP_SATURATE_EN
  // Sticky clip bit covers the whole period, including the dumped sample.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sticky   <= 1'b0;
      r_sat_flag <= 1'b0;
    end else if (w_dump) begin
      r_sticky   <= 1'b0;
      r_sat_flag <= r_sticky || (|w_clip);
    end else begin
      r_sticky   <= r_sticky || (|w_clip);
    end
  end
  assign sat_flag = r_sat_flag;
`else
  assign sat_flag = 1'b0;
`endif

  assign out_e_i   = r_out[0];
  assign out_e_q   = r_out[1];
  assign out_p_i   = r_out[2];
  assign out_p_q   = r_out[3];
  assign out_l_i   = r_out[4];
  assign out_l_q   = r_out[5];
  assign out_count = r_out_count;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;
  assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: doc/integrate_dump.md
INTEGRATE_DUMP -- requirements
Module: integrate_dump

Interface
REQ-001 The block SHALL have these parameters:
- IN_W, 16, width of each signed correlator input.
- ACC_W, 32, width of each signed accumulator and dump output.
- MAX_SAMPLES, 16368, number of samples after which a dump is forced without an epoch.
- CNT_W, 16, sample counter width.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK, in, 1, single clock; all state on its rising edge.
- RST, in, 1, asynchronous active-low reset.
- sample_valid, in, 1, inputs below carry a new sample.
- epoch, in, 1, C/A code epoch strobe (end of integration period).
- in_e_i, in_e_q, in_p_i, in_p_q, in_l_i, in_l_q, in, IN_W each, signed early/prompt/late I/Q correlator products.
- out_e_i, out_e_q, out_p_i, out_p_q, out_l_i, out_l_q, out, ACC_W each, signed dumped sums.
- out_count, out, CNT_W, samples accumulated in the dumped period.
- out_valid, out, 1, dump held and available.
- out_ready, in, 1, consumer (DLL/Costas) accepts the dump.
- overrun, out, 1, one-cycle pulse: an unconsumed dump was overwritten.
- timeout, out, 1, one-cycle pulse: dump was forced by MAX_SAMPLES.
- sat_flag, out, 1, at least one accumulator clipped in the held dump.

Function
REQ-003 The block SHALL keep six ACC_W accumulators and one CNT_W sample counter, each input sign-extended before addition.
REQ-004 When sample_valid=1 and no dump event occurs, each accumulator SHALL add its input and the counter SHALL increment.
REQ-005 A dump event SHALL be epoch=1, or (sample_valid=1 and the counter equals MAX_SAMPLES-1).
REQ-006 On a dump event with sample_valid=1, that sample SHALL be included in the dumped sums and count; with sample_valid=0, the current accumulator values SHALL be dumped.
REQ-007 On a dump event, accumulators and counter SHALL be cleared to 0 in the same edge; the next sample starts a new period.
REQ-008 Dumped values SHALL appear on the out_* ports with out_valid=1 on the cycle after the dump event (latency 1).
REQ-009 out_valid SHALL remain 1 with stable outputs until a cycle with out_ready=1; it then clears on the next edge unless a new dump coincides.
REQ-010 If a dump occurs while out_valid=1 and out_ready=0, the new dump SHALL overwrite the outputs and overrun SHALL pulse for one cycle.
REQ-011 If a dump coincides with out_ready=1 while out_valid=1, the new dump SHALL load, out_valid SHALL stay 1, and overrun SHALL stay 0.
REQ-012 timeout SHALL pulse together with the first out_valid cycle of a dump caused only by MAX_SAMPLES; if epoch coincides with the limit, timeout SHALL stay 0.
REQ-013 A dump event with counter=0 and sample_valid=0 SHALL still produce a dump of zeros with out_count=0.

Reset
REQ-014 While RST=0, all accumulators, the counter, every out_* bus, out_count, out_valid, overrun, timeout and sat_flag SHALL be 0, asynchronously.
REQ-015 Deassertion of RST SHALL take effect on the next CLK edge; any partial integration in progress at reset SHALL be discarded.

Configuration
REQ-016 With macro INTEGRATE_DUMP_SATURATE_EN defined:
- each accumulation SHALL clamp to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) on overflow;
- a per-period sticky clip bit SHALL be copied to sat_flag on dump.
REQ-017 With the macro undefined:
- accumulation SHALL wrap in two's complement;
- sat_flag SHALL be constant 0.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Basic dump: 10 samples of in_p_i=+3 and in_e_q=-2, epoch on the 10th sample -> next cycle out_valid=1, out_p_i=30, out_e_q=-20, out_count=10.
- Back-pressure and overrun: out_ready=0, two epochs 5 samples apart -> overrun pulses once; outputs hold the second dump; out_valid stays 1 until out_ready=1.
- Forced dump: MAX_SAMPLES=8, no epoch, continuous sample_valid -> dump every 8 samples with out_count=8 and timeout pulsing each dump.
- Saturation: ACC_W=16, in_l_i=+32767 for 3 samples. With INTEGRATE_DUMP_SATURATE_EN defined -> out_l_i=32767, sat_flag=1. Undefined -> out_l_i equals the wrapped value 32765, sat_flag=0.
- Reset mid-integration: assert RST after 5 samples, release, 4 samples then epoch -> out_count=4 and all outputs reflect only the post-reset samples.
- Coincident ready and dump: out_valid=1, out_ready=1 in the same cycle as an epoch -> new data loads, out_valid stays 1, overrun=0.
